// File: rtl/gen_reg_master.sv
// gen_reg_master: command-driven initiator for a synchronous register-file
// slave. Accepts READ / WRITE / ADD commands over a valid/ready handshake,
// sequences the slave accesses and returns one response per command.
module gen_reg_master #(
  parameter int D_WIDTH = 16,
  parameter int REG_NO  = 16,
  parameter int A_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [A_WIDTH-1:0] cmd_addr,
  input  logic [D_WIDTH-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_WIDTH-1:0] rsp_data,
  output logic               rsp_err,
  output logic               rsp_carry,
  output logic               cs,
  output logic               we,
  output logic [A_WIDTH-1:0] addr,
  output logic [D_WIDTH-1:0] din,
  input  logic [D_WIDTH-1:0] dout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_RDWAIT = 3'd2,
    S_WB     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  // One extra bit so REG_NO == 2^A_WIDTH is representable in the compare.
  localparam logic [A_WIDTH:0] LP_REG_NO = (A_WIDTH + 1)'(REG_NO);

  // Full-width add; the top bit is the carry out of the register-width sum.
  function automatic logic [D_WIDTH:0] add_wide(input logic [D_WIDTH-1:0] a,
                                                input logic [D_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [A_WIDTH-1:0]   r_addr;
  logic [D_WIDTH-1:0]   r_data;
  logic [D_WIDTH-1:0]   r_rsp_data;
  logic                 r_rsp_err;
  logic                 r_rsp_carry;
  logic                 w_cmd_fire;
  logic                 w_cmd_ok;
  logic [D_WIDTH:0]     w_sum;

  assign w_cmd_fire = (r_state == S_IDLE) && cmd_valid;
  assign w_cmd_ok   = (cmd_op != OP_RSVD) && ({1'b0, cmd_addr} < LP_REG_NO);
  assign w_sum      = add_wide(dout, r_data);

  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign rsp_carry  = r_rsp_carry;

  // State register; reset drops any command in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus bus/handshake outputs decoded from the current state.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    cs        = 1'b0;
    we        = 1'b0;
    addr      = '0;
    din       = '0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = w_cmd_ok ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        cs   = 1'b1;
        addr = r_addr;
        if (r_op == OP_WRITE) begin
          we     = 1'b1;
          din    = r_data;
          w_next = S_RESP;
        end else if (r_op == OP_READ) begin
          w_next = S_RDWAIT;
        end else begin
          w_next = S_WB;
        end
      end
      S_RDWAIT: w_next = S_RESP;
      S_WB: begin
        cs     = 1'b1;
        we     = 1'b1;
        addr   = r_addr;
        din    = w_sum[D_WIDTH-1:0];
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch and response registers; response fields hold while in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_op        <= cmd_op;
            r_addr      <= cmd_addr;
            r_data      <= cmd_data;
            r_rsp_carry <= 1'b0;
            if (w_cmd_ok) begin
              r_rsp_err  <= 1'b0;
            end else begin
              r_rsp_err  <= 1'b1;
              r_rsp_data <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (r_op == OP_WRITE) r_rsp_data <= r_data;
        end
        S_RDWAIT: r_rsp_data <= dout;
        S_WB: begin
          r_rsp_data  <= w_sum[D_WIDTH-1:0];
          r_rsp_carry <= w_sum[D_WIDTH];
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_err   <= 1'b0;
            r_rsp_carry <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_reg_master.sv
// Directed bench for gen_reg_master with a behavioural synchronous
// register-file slave (REG_NO=12 so out-of-range addresses exist).
module tb_gen_reg_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rsp_carry;
  logic        cs;
  logic        we;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] mem [16];

  gen_reg_master #(.D_WIDTH(16), .REG_NO(12), .A_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_carry(rsp_carry),
    .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous slave: write on cs&we, read data appears the cycle after cs.
  always @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it until rsp_valid (bounded), recording bus activity.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
                         output int lat, output int ncs, output int nwr,
                         output logic [15:0] wdin, output logic [3:0] caddr);
    ncs = 0; nwr = 0; wdin = '0; caddr = '0; lat = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr = 4'hF; cmd_data = 16'hDEAD;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (cs) begin
        ncs++;
        caddr = addr;
        if (we) begin nwr++; wdin = din; end
      end
      @(negedge clk);
      lat++;
    end
  endtask

  // Let the response handshake complete (rsp_ready assumed 1) and confirm IDLE.
  task automatic finish_rsp(input string tag);
    @(negedge clk);
    chk({tag, "_rsp_valid_clr"}, 32'(rsp_valid), 0);
    chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 1);
  endtask

  int lat, ncs, nwr;
  logic [15:0] wdin;
  logic [3:0]  caddr;

  initial begin
    foreach (mem[i]) mem[i] = 16'h0000;
    dout = 16'h0000;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 4'h0;
    cmd_data = 16'h0000; rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cs", 32'(cs), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_din", 32'(din), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_carry", 32'(rsp_carry), 0);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);

    // WRITE addr 3 0xA5A5
    run_cmd(2'b01, 4'd3, 16'hA5A5, lat, ncs, nwr, wdin, caddr);
    chk("wr_lat", lat, 2);
    chk("wr_ncs", ncs, 1);
    chk("wr_nwr", nwr, 1);
    chk("wr_din", 32'(wdin), 32'hA5A5);
    chk("wr_addr", 32'(caddr), 3);
    chk("wr_rsp_data", 32'(rsp_data), 32'hA5A5);
    chk("wr_rsp_err", 32'(rsp_err), 0);
    chk("wr_cmd_ready_busy", 32'(cmd_ready), 0);
    finish_rsp("wr");

    // READ addr 3
    run_cmd(2'b00, 4'd3, 16'h0000, lat, ncs, nwr, wdin, caddr);
    chk("rd_lat", lat, 3);
    chk("rd_ncs", ncs, 1);
    chk("rd_nwr", nwr, 0);
    chk("rd_addr", 32'(caddr), 3);
    chk("rd_rsp_data", 32'(rsp_data), 32'hA5A5);
    chk("rd_rsp_err", 32'(rsp_err), 0);
    finish_rsp("rd");

    // Preload reg5 = 0xFFFF, then ADD 0x0001 wraps to 0 with carry
    run_cmd(2'b01, 4'd5, 16'hFFFF, lat, ncs, nwr, wdin, caddr);
    chk("wr5_lat", lat, 2);
    finish_rsp("wr5");
    run_cmd(2'b10, 4'd5, 16'h0001, lat, ncs, nwr, wdin, caddr);
    chk("add_lat", lat, 3);
    chk("add_ncs", ncs, 2);
    chk("add_nwr", nwr, 1);
    chk("add_din", 32'(wdin), 32'h0000);
    chk("add_addr", 32'(caddr), 5);
    chk("add_rsp_data", 32'(rsp_data), 32'h0000);
    chk("add_rsp_carry", 32'(rsp_carry), 1);
    chk("add_rsp_err", 32'(rsp_err), 0);
    finish_rsp("add");
    chk("add_carry_clr", 32'(rsp_carry), 0);

    run_cmd(2'b00, 4'd5, 16'h0000, lat, ncs, nwr, wdin, caddr);
    chk("rd5_rsp_data", 32'(rsp_data), 32'h0000);
    chk("rd5_rsp_carry", 32'(rsp_carry), 0);
    finish_rsp("rd5");

    // ADD without carry: 0xA5A5 + 0x0001
    run_cmd(2'b10, 4'd3, 16'h0001, lat, ncs, nwr, wdin, caddr);
    chk("add3_din", 32'(wdin), 32'hA5A6);
    chk("add3_rsp_data", 32'(rsp_data), 32'hA5A6);
    chk("add3_rsp_carry", 32'(rsp_carry), 0);
    finish_rsp("add3");

    // Bad address 13
    run_cmd(2'b00, 4'd13, 16'h0000, lat, ncs, nwr, wdin, caddr);
    chk("bad13_lat", lat, 1);
    chk("bad13_ncs", ncs, 0);
    chk("bad13_cs", 32'(cs), 0);
    chk("bad13_rsp_err", 32'(rsp_err), 1);
    chk("bad13_rsp_data", 32'(rsp_data), 0);
    finish_rsp("bad13");
    chk("bad13_err_clr", 32'(rsp_err), 0);

    // First out-of-range address 12
    run_cmd(2'b01, 4'd12, 16'h7777, lat, ncs, nwr, wdin, caddr);
    chk("bad12_lat", lat, 1);
    chk("bad12_ncs", ncs, 0);
    chk("bad12_rsp_err", 32'(rsp_err), 1);
    finish_rsp("bad12");

    // Reserved op on a legal address
    run_cmd(2'b11, 4'd3, 16'h1234, lat, ncs, nwr, wdin, caddr);
    chk("rsvd_lat", lat, 1);
    chk("rsvd_ncs", ncs, 0);
    chk("rsvd_rsp_err", 32'(rsp_err), 1);
    chk("rsvd_rsp_data", 32'(rsp_data), 0);
    chk("rsvd_rsp_carry", 32'(rsp_carry), 0);
    finish_rsp("rsvd");

    // Highest legal address 11
    run_cmd(2'b01, 4'd11, 16'h1234, lat, ncs, nwr, wdin, caddr);
    chk("max_wr_lat", lat, 2);
    chk("max_wr_err", 32'(rsp_err), 0);
    finish_rsp("max_wr");
    run_cmd(2'b00, 4'd11, 16'h0000, lat, ncs, nwr, wdin, caddr);
    chk("max_rd_data", 32'(rsp_data), 32'h1234);
    finish_rsp("max_rd");

    // Back-pressure: READ addr 3 with rsp_ready low, competing command waiting
    rsp_ready = 1'b0;
    run_cmd(2'b00, 4'd3, 16'h0000, lat, ncs, nwr, wdin, caddr);
    chk("bp_lat", lat, 3);
    chk("bp_rsp_data", 32'(rsp_data), 32'hA5A6);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd3; cmd_data = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_data", 32'(rsp_data), 32'hA5A6);
      chk("bp_hold_cmd_ready", 32'(cmd_ready), 0);
      chk("bp_hold_cs", 32'(cs), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", 32'(rsp_valid), 0);
    chk("bp_rel_cmd_ready", 32'(cmd_ready), 1);
    chk("bp_rel_cs", 32'(cs), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_cs", 32'(cs), 1);
    chk("bp_next_we", 32'(we), 1);
    chk("bp_next_din", 32'(din), 32'h1111);
    @(negedge clk);
    chk("bp_next_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_next_rsp_data", 32'(rsp_data), 32'h1111);
    finish_rsp("bp_next");

    // Reset asserted in the WB cycle of an ADD
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 4'd5; cmd_data = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rwb_issue_cs", 32'(cs), 1);
    chk("rwb_issue_we", 32'(we), 0);
    @(negedge clk);
    chk("rwb_wb_we", 32'(we), 1);
    chk("rwb_wb_din", 32'(din), 32'h0002);
    rst = 1'b1;
    #1;
    chk("rwb_rst_cs", 32'(cs), 0);
    chk("rwb_rst_we", 32'(we), 0);
    chk("rwb_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rwb_rst_rsp_data", 32'(rsp_data), 0);
    chk("rwb_rst_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rwb_rel_cmd_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rwb_quiet_rsp_valid", 32'(rsp_valid), 0);
      chk("rwb_quiet_cs", 32'(cs), 0);
    end
    run_cmd(2'b00, 4'd3, 16'h0000, lat, ncs, nwr, wdin, caddr);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", 32'(rsp_data), 32'h1111);
    finish_rsp("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
